// File: rtl/game_pkg.sv
// game_pkg: shared display constants, bullet slot layout and colour mapping.
package game_pkg;
  localparam int CELL_W = 5;
  localparam int ROW_W = 40;
  localparam logic [4:0] DARK = 5'd31;
  localparam logic [4:0] COL_A = 5'd10;
  localparam logic [4:0] COL_B = 5'd11;
  localparam logic [4:0] COL_C = 5'd12;
  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
    logic [4:0] color;
  } slot_t;
  function automatic logic [4:0] map_color(input logic [7:0] v);
    return v[1:0] == 2'd1 ? COL_B : v[1:0] == 2'd2 ? COL_C : COL_A;
  endfunction
endpackage

// File: rtl/color_lfsr.sv
// color_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) stepping every cycle.
module color_lfsr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed,
  output logic [7:0] out
);
  logic [7:0] lfsr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= seed;
    else lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign out = lfsr_q;
endmodule

// File: rtl/bullet_manager.sv
// bullet_manager: bullet pool with spawn on fire edge, stepping on tick and retirement past row 7.
module bullet_manager
  import game_pkg::*;
#(
  parameter int         NUM_SLOTS = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fire,
  input  logic             tick,
  input  logic [2:0]       player_pos,
  input  logic [2:0]       row_sel,
  output logic [ROW_W-1:0] bullet_row,
  output logic             shot_valid,
  output logic [2:0]       shot_col,
  output logic [4:0]       shot_color,
  output logic             fire_drop,
  output logic [3:0]       active_cnt
);
  slot_t [NUM_SLOTS-1:0] slot_q, slot_d;
  logic       fire_q, shot_valid_q, fire_drop_q;
  logic [2:0] shot_col_q, ret_col, free_idx;
  logic [4:0] shot_color_q, ret_color;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] lfsr;
  logic       step, fire_edge, row0_busy, has_free, spawn, retire;

  color_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .seed(LFSR_SEED), .out(lfsr));

  // row 0 only counts as busy when no tick moves its occupant away this cycle
  always_comb begin
    slot_d = slot_q;
    step = en & tick;
    fire_edge = fire & ~fire_q;
    row0_busy = 1'b0;
    has_free = 1'b0;
    free_idx = '0;
    retire = 1'b0;
    ret_col = '0;
    ret_color = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!slot_q[i].valid) begin
        has_free = 1'b1;
        free_idx = 3'(i);
      end
    for (int i = 0; i < NUM_SLOTS; i++)
      if (slot_q[i].valid) begin
        if (slot_q[i].row == 3'd0 && !step) row0_busy = 1'b1;
        if (step && slot_q[i].row == 3'd7) begin
          slot_d[i].valid = 1'b0;
          retire = 1'b1;
          ret_col = slot_q[i].col;
          ret_color = slot_q[i].color;
        end else if (step) slot_d[i].row = slot_q[i].row + 3'd1;
      end
    spawn = en & fire_edge & has_free & ~row0_busy;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (spawn && free_idx == 3'(i)) slot_d[i] = '{valid: 1'b1, row: 3'd0, col: player_pos, color: map_color(lfsr)};
    cnt_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) cnt_d = cnt_d + 4'(slot_d[i].valid);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_q <= '0;
      fire_q <= 1'b1;
      shot_valid_q <= 1'b0;
      shot_col_q <= '0;
      shot_color_q <= '0;
      fire_drop_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      slot_q <= slot_d;
      fire_q <= fire;
      shot_valid_q <= retire;
      fire_drop_q <= en & fire_edge & ~spawn;
      cnt_q <= cnt_d;
      if (retire) begin
        shot_col_q <= ret_col;
        shot_color_q <= ret_color;
      end
    end

  always_comb begin
    bullet_row = {8{DARK}};
    for (int i = 0; i < NUM_SLOTS; i++)
      if (slot_q[i].valid && slot_q[i].row == row_sel)
        bullet_row[int'(slot_q[i].col) * CELL_W +: CELL_W] = slot_q[i].color;
  end

  assign shot_valid = shot_valid_q;
  assign shot_col = shot_col_q;
  assign shot_color = shot_color_q;
  assign fire_drop = fire_drop_q;
  assign active_cnt = cnt_q;
endmodule

// File: tb/tb_bullet_manager.sv
// tb_bullet_manager: directed checks of spawn, step, retire, drop, enable and reset behaviour.
module tb_bullet_manager;
  logic        clk = 0, rst_n = 0, en = 1, fire = 0, tick = 0;
  logic [2:0]  player_pos = 3, row_sel = 0;
  logic [39:0] bullet_row;
  logic        shot_valid, fire_drop;
  logic [2:0]  shot_col;
  logic [4:0]  shot_color;
  logic [3:0]  active_cnt;
  logic [7:0]  lfsr_m;
  logic [4:0]  c0, c1, c2, c3;
  int total = 0, bad = 0;
  localparam logic [39:0] ALL_DARK = {8{5'd31}};

  bullet_manager #(.NUM_SLOTS(4), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fire(fire), .tick(tick),
    .player_pos(player_pos), .row_sel(row_sel), .bullet_row(bullet_row),
    .shot_valid(shot_valid), .shot_col(shot_col), .shot_color(shot_color),
    .fire_drop(fire_drop), .active_cnt(active_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_m <= 8'hA5;
    else lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};

  function automatic logic [4:0] mapc(input logic [7:0] v);
    return v[1:0] == 2'd1 ? 5'd11 : v[1:0] == 2'd2 ? 5'd12 : 5'd10;
  endfunction

  function automatic logic [39:0] row_with(input int c, input logic [4:0] col);
    logic [39:0] r;
    r = ALL_DARK;
    r[c*5 +: 5] = col;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic t);
    fire = f;
    tick = t;
    cyc();
    fire = 0;
    tick = 0;
  endtask

  task automatic look(input logic [2:0] r);
    row_sel = r;
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_cnt", active_cnt, 0);
    chk("rst_shot", shot_valid, 0);
    chk("rst_drop", fire_drop, 0);
    chk("rst_row", bullet_row, ALL_DARK);
    rst_n = 1;
    cyc();
    // single bullet flight and retirement
    c0 = mapc(lfsr_m);
    drive(1, 0);
    look(0);
    chk("spawn_row0", bullet_row, row_with(3, c0));
    chk("spawn_cnt", active_cnt, 1);
    chk("spawn_nodrop", fire_drop, 0);
    for (int k = 1; k <= 7; k++) begin
      drive(0, 1);
      look(3'(k));
      chk($sformatf("fly_row%0d", k), bullet_row, row_with(3, c0));
      chk($sformatf("fly_noshot%0d", k), shot_valid, 0);
    end
    look(6);
    chk("fly_left_row6", bullet_row, ALL_DARK);
    drive(0, 1);
    chk("shot_valid", shot_valid, 1);
    chk("shot_col", shot_col, 3);
    chk("shot_color", shot_color, c0);
    chk("shot_cnt", active_cnt, 0);
    look(7);
    chk("shot_row7_dark", bullet_row, ALL_DARK);
    cyc();
    chk("shot_pulse_end", shot_valid, 0);
    // second fire edge with bullet still in row 0
    c1 = mapc(lfsr_m);
    drive(1, 0);
    cyc();
    drive(1, 0);
    chk("drop_row0", fire_drop, 1);
    chk("drop_cnt", active_cnt, 1);
    cyc();
    chk("drop_pulse_end", fire_drop, 0);
    // tick and fire edge together
    player_pos = 5;
    c2 = mapc(lfsr_m);
    drive(1, 1);
    chk("tf_nodrop", fire_drop, 0);
    chk("tf_cnt", active_cnt, 2);
    look(1);
    chk("tf_row1", bullet_row, row_with(3, c1));
    look(0);
    chk("tf_row0", bullet_row, row_with(5, c2));
    // fill the pool, then overflow
    drive(0, 1);
    player_pos = 6;
    c3 = mapc(lfsr_m);
    drive(1, 0);
    drive(0, 1);
    player_pos = 1;
    drive(1, 0);
    chk("fill_cnt", active_cnt, 4);
    drive(0, 1);
    drive(1, 0);
    chk("full_drop", fire_drop, 1);
    chk("full_cnt", active_cnt, 4);
    look(0);
    chk("full_row0_dark", bullet_row, ALL_DARK);
    // enable low holds everything
    en = 0;
    for (int k = 0; k < 10; k++) drive(k == 4, 1);
    chk("en0_cnt", active_cnt, 4);
    chk("en0_shot", shot_valid, 0);
    chk("en0_drop", fire_drop, 0);
    look(4);
    chk("en0_row4", bullet_row, row_with(3, c1));
    look(3);
    chk("en0_row3", bullet_row, row_with(5, c2));
    look(2);
    chk("en0_row2", bullet_row, row_with(6, c3));
    en = 1;
    // async reset mid-flight with fire held
    look(4);
    fire = 1;
    rst_n = 0;
    #2;
    chk("arst_row", bullet_row, ALL_DARK);
    chk("arst_cnt", active_cnt, 0);
    chk("arst_shot", shot_valid, 0);
    cyc();
    rst_n = 1;
    for (int k = 0; k < 3; k++) cyc();
    chk("held_cnt", active_cnt, 0);
    chk("held_drop", fire_drop, 0);
    chk("held_shot", shot_valid, 0);
    look(0);
    chk("held_row0", bullet_row, ALL_DARK);
    fire = 0;
    cyc();
    player_pos = 7;
    c0 = mapc(lfsr_m);
    drive(1, 0);
    chk("post_rst_spawn", bullet_row, row_with(7, c0));
    chk("post_rst_cnt", active_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
